data_deplexer_en: RTL and testbench
===================================

Name: data_deplexer_en

Overview:
- Receive end of the lane-plexer interface: accepts one INPUT_WIDTH word per beat, tagged with a one-hot lane enable, and reassembles the words into a full 2**SEL-lane frame.
- Presents the completed frame on a wide bus with a valid/ready handshake.
- Sits downstream of a plexer stage that serialises a wide bus onto a narrow link.

Parameters:
INPUT_WIDTH, 4, width of one lane word
SEL, 1, lane-select width; number of lanes N = 2**SEL

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of the partial frame; highest priority after reset
data_in  input  INPUT_WIDTH  lane word
data_en  input  N  one-hot lane tag for data_in
in_valid  input  1  beat offered
in_ready  output  1  beat accepted when in_valid & in_ready
data_out  output  INPUT_WIDTH*N  assembled frame; lane k at [k*INPUT_WIDTH +: INPUT_WIDTH]
lane_mask  output  N  lanes captured so far in the current frame
out_valid  output  1  frame complete
out_ready  input  1  consumer takes the frame when out_valid & out_ready
err_tag  output  1  one-cycle pulse: an accepted beat had a non-one-hot data_en
err_dup  output  1  one-cycle pulse: an accepted beat targeted a lane already in lane_mask

Behaviour:
- Reset (rst_n low, asynchronous): state = COLLECT.
  - data_out, lane_mask, out_valid, err_tag and err_dup are all 0.
  - in_ready is 1 once rst_n is released.
- States: COLLECT and HOLD. in_ready = (state == COLLECT), combinational from state only. out_valid = (state == HOLD), registered.
- COLLECT, on an accepted beat:
  - data_en not one-hot (zero, or two or more bits set): beat dropped; data_out and lane_mask unchanged; err_tag = 1 for the next cycle.
  - data_en one-hot at lane k, and lane_mask[k] = 0: data_out lane k <= data_in; lane_mask[k] <= 1.
  - data_en one-hot at lane k, and lane_mask[k] = 1: lane k is overwritten with data_in; err_dup = 1 for the next cycle; lane_mask is unchanged.
  - If lane_mask including this beat's bit equals all-ones, state <= HOLD on the same edge. out_valid is high in the cycle after the final beat (latency 1 from the final accepted beat).
- HOLD:
  - in_ready = 0; data_out is stable and in_valid is ignored.
  - On out_ready: state <= COLLECT and lane_mask <= 0. data_out keeps its old contents (don't-care to the consumer). in_ready returns to 1 on the next cycle; there is no same-cycle pass-through.
- clear = 1: on the next edge, state <= COLLECT and lane_mask <= 0.
  - Any in-flight beat in that cycle is discarded, with no error pulses.
  - A pending out_valid is withdrawn even if out_ready is low.
- Error pulses are registered, last exactly one cycle per offending beat, and are independent of each other.
- Lanes may arrive in any order; frame completion depends only on the mask, not on arrival order.
- Degenerate case SEL such that N = 1: every valid one-hot beat completes a frame; err_dup cannot fire.
- rst_n asserted mid-frame or in HOLD: immediate return to reset values; the partial frame is lost.
- Sizing: an implementation of 120–400 RTL lines is expected.

Test Plan:
- SEL=2, INPUT_WIDTH=4; beats (en=0001,d=A), (0010,B), (0100,C), (1000,D) with out_ready=1 -> out_valid=1 one cycle after the 4th beat, data_out=16'hDCBA, lane_mask=1111; next cycle in_ready=1 and lane_mask=0000.
- Out-of-order lanes 1000/D, 0001/A, 0100/C, 0010/B with out_ready=0 for 5 cycles -> data_out=16'hDCBA held stable, in_ready=0 throughout HOLD; a beat offered during HOLD is not accepted; frame released only on out_ready.
- Beat with en=0011 and beat with en=0000 -> err_tag pulses one cycle each; lane_mask unchanged; frame still completes after four valid lanes.
- Lane 0 written with 5, then lane 0 written with 7 -> err_dup one-cycle pulse; final data_out[3:0]=7; lane_mask[0] stays 1; out_valid only after lanes 1–3 also arrive.
- clear asserted after two lanes, in the same cycle as a lane-2 beat -> lane_mask=0000 next cycle, no error pulses, lane-2 beat discarded; a fresh 4-beat frame completes normally.
- rst_n pulled low while in HOLD (asynchronous, mid-cycle) -> out_valid, lane_mask and data_out drop to 0 immediately, without waiting for a clock edge; in_ready=1 after release.

Source files
------------

// File: rtl/data_deplexer_en.sv
// Lane de-plexer: gathers one-hot-tagged lane words into a full 2**SEL-lane frame
// and offers the completed frame downstream with a valid/ready handshake.
module data_deplexer_en #(
  parameter int INPUT_WIDTH = 4,
  parameter int SEL         = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic [INPUT_WIDTH-1:0]              data_in,
  input  logic [(1<<SEL)-1:0]                 data_en,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [INPUT_WIDTH*(1<<SEL)-1:0]     data_out,
  output logic [(1<<SEL)-1:0]                 lane_mask,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                err_tag,
  output logic                                err_dup
);

  localparam int N = 1 << SEL;
  localparam int W = INPUT_WIDTH;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Handshakes: a beat moves when in_valid & in_ready; a frame moves when
  // out_valid & out_ready. Neither ready depends on the matching valid.
  state_e         state_q, state_d;
  logic [W*N-1:0] data_q, data_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           err_tag_q, err_tag_d;
  logic           err_dup_q, err_dup_d;

  logic           accept;
  logic           tag_ok;
  logic [N-1:0]   mask_next;

  assign accept    = in_valid && (state_q == COLLECT) && !clear;
  assign tag_ok    = $onehot(data_en);
  assign mask_next = mask_q | data_en;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    err_tag_d = 1'b0;
    err_dup_d = 1'b0;

    if (clear) begin
      // Flush wins over everything, including a frame waiting in HOLD.
      state_d = COLLECT;
      mask_d  = '0;
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        state_d = COLLECT;
        mask_d  = '0;
      end
    end else if (accept) begin
      if (!tag_ok) begin
        err_tag_d = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (data_en[k]) begin
            data_d[k*W +: W] = data_in;
          end
        end
        err_dup_d = |(mask_q & data_en);
        mask_d    = mask_next;
        if (mask_next == {N{1'b1}}) begin
          state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      data_q    <= '0;
      mask_q    <= '0;
      err_tag_q <= 1'b0;
      err_dup_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      err_tag_q <= err_tag_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign data_out  = data_q;
  assign lane_mask = mask_q;
  assign err_tag   = err_tag_q;
  assign err_dup   = err_dup_q;

endmodule

// File: tb/tb_data_deplexer_en.sv
// Bench for data_deplexer_en (SEL=2, 4-bit lanes): directed frames from the
// test plan, then randomized traffic checked every cycle against a lane-array model.
module tb_data_deplexer_en;

  localparam int W   = 4;
  localparam int SEL = 2;
  localparam int N   = 4;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic [W-1:0]   data_in;
  logic [N-1:0]   data_en;
  logic           in_valid;
  logic           in_ready;
  logic [W*N-1:0] data_out;
  logic [N-1:0]   lane_mask;
  logic           out_valid;
  logic           out_ready;
  logic           err_tag;
  logic           err_dup;

  data_deplexer_en #(.INPUT_WIDTH(W), .SEL(SEL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .data_in   (data_in),
    .data_en   (data_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .lane_mask (lane_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_tag   (err_tag),
    .err_dup   (err_dup)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps each lane as an array entry and the captured set as an int
  // bitmask; a frame is "held" once all four lanes have been seen.
  logic [W-1:0]   m_lane [N];
  int             m_mask;
  bit             m_hold;
  bit             m_etag;
  bit             m_edup;
  logic [W*N-1:0] exp_q [$];

  function automatic logic [W*N-1:0] model_frame();
    logic [W*N-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = m_lane[k];
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < N; k++) m_lane[k] = '0;
        m_mask = 0;
        m_hold = 0;
        m_etag = 0;
        m_edup = 0;
        exp_q.delete();
      end else begin
        m_etag = 0;
        m_edup = 0;
        if (clear) begin
          if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
          m_hold = 0;
          m_mask = 0;
        end else if (m_hold) begin
          if (out_ready) begin
            m_hold = 0;
            m_mask = 0;
          end
        end else if (in_valid) begin
          if ($countones(data_en) != 1) begin
            m_etag = 1;
          end else begin
            for (int k = 0; k < N; k++) begin
              if (data_en[k]) begin
                if (m_mask & (1 << k)) m_edup = 1;
                m_lane[k] = data_in;
                m_mask    = m_mask | (1 << k);
              end
            end
            if (m_mask == 15) begin
              m_hold = 1;
              exp_q.push_back(model_frame());
            end
          end
        end
      end
    end
  end

  // ---------------- compare process (falling edge) ----------------
  bit cmp_en = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("in_ready",  in_ready,  !m_hold);
        chk("out_valid", out_valid, m_hold);
        chk("lane_mask", lane_mask, m_mask[N-1:0]);
        chk("data_out",  data_out,  model_frame());
        chk("err_tag",   err_tag,   m_etag);
        chk("err_dup",   err_dup,   m_edup);
        // Scoreboard: each frame taken by the consumer must match the oldest completed one.
        if (rst_n && out_valid && out_ready && !clear) begin
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 1, 0);
          end else begin
            chk("frame_taken", data_out, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [N-1:0] en, input logic [W-1:0] d,
                     input logic ordy, input logic clr);
    in_valid  = v;
    data_en   = en;
    data_in   = d;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] en, input logic [W-1:0] d, input logic ordy);
    cyc(1'b1, en, d, ordy, 1'b0);
  endtask

  task automatic release_frame();
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_lane_mask", lane_mask, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear = 1'b0; data_in = '0; data_en = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lane_mask", lane_mask, 0);
    chk("rst_data_out",  data_out,  0);
    chk("rst_err_tag",   err_tag,   0);
    chk("rst_err_dup",   err_dup,   0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1;

    // In-order frame with out_ready already high.
    beat(4'b0001, 4'hA, 1); beat(4'b0010, 4'hB, 1); beat(4'b0100, 4'hC, 1);
    chk("t1_not_yet", out_valid, 0);
    beat(4'b1000, 4'hD, 1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_data_out",  data_out,  16'hDCBA);
    chk("t1_lane_mask", lane_mask, 4'hF);
    release_frame();

    // Out-of-order frame held for 5 cycles with a beat pushed at it.
    beat(4'b1000, 4'hD, 0); beat(4'b0001, 4'hA, 0); beat(4'b0100, 4'hC, 0); beat(4'b0010, 4'hB, 0);
    for (int i = 0; i < 5; i++) begin
      beat(4'b0001, 4'h5, 0);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_ready", in_ready,  0);
      chk("t2_hold_data",  data_out,  16'hDCBA);
    end
    release_frame();

    // Bad tags.
    beat(4'b0011, 4'h1, 0);
    chk("t3_err_tag_a", err_tag, 1);
    chk("t3_mask_a", lane_mask, 0);
    cyc(1'b0, '0, '0, 0, 0);
    chk("t3_err_tag_off", err_tag, 0);
    beat(4'b0000, 4'h2, 0);
    chk("t3_err_tag_b", err_tag, 1);
    beat(4'b0001, 4'h3, 0); beat(4'b0010, 4'h4, 0); beat(4'b0100, 4'h5, 0); beat(4'b1000, 4'h6, 0);
    chk("t3_done", out_valid, 1);
    chk("t3_data", data_out, 16'h6543);
    release_frame();

    // Duplicate lane.
    beat(4'b0001, 4'h5, 0);
    beat(4'b0001, 4'h7, 0);
    chk("t4_err_dup", err_dup, 1);
    chk("t4_err_tag", err_tag, 0);
    chk("t4_mask", lane_mask, 4'b0001);
    beat(4'b0010, 4'h8, 0); beat(4'b0100, 4'h9, 0);
    chk("t4_err_dup_off", err_dup, 0);
    chk("t4_not_yet", out_valid, 0);
    beat(4'b1000, 4'hE, 0);
    chk("t4_done", out_valid, 1);
    chk("t4_lane0", data_out[3:0], 4'h7);
    release_frame();

    // Clear alongside a lane-2 beat.
    beat(4'b0001, 4'h1, 0); beat(4'b0010, 4'h2, 0);
    cyc(1'b1, 4'b0100, 4'hC, 0, 1);
    chk("t5_mask", lane_mask, 0);
    chk("t5_err_tag", err_tag, 0);
    chk("t5_err_dup", err_dup, 0);
    chk("t5_lane2_kept", data_out[11:8], 4'h9);
    beat(4'b0100, 4'h3, 0); beat(4'b1000, 4'h4, 0); beat(4'b0010, 4'h2, 0); beat(4'b0001, 4'h1, 0);
    chk("t5_done", out_valid, 1);
    chk("t5_data", data_out, 16'h4321);
    release_frame();

    // Asynchronous reset while holding a frame.
    beat(4'b0001, 4'hA, 0); beat(4'b0010, 4'hB, 0); beat(4'b0100, 4'hC, 0); beat(4'b1000, 4'hD, 0);
    chk("t6_hold", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_lane_mask", lane_mask, 0);
    chk("t6_data_out",  data_out,  0);
    chk("t6_in_ready",  in_ready,  1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_ready_after", in_ready, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] en;
      if ($urandom_range(0, 7) == 0) en = N'($urandom_range(0, 15));
      else en = N'(1 << $urandom_range(0, 3));
      cyc(($urandom_range(0, 3) != 0), en, W'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
    end
    cyc(1'b0, '0, '0, 1, 0);
    cyc(1'b0, '0, '0, 1, 0);
    chk("frames_drained", exp_q.size(), 0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
